adler32_check: RTL and testbench
================================

# adler32_check

Streaming Adler-32 frame checker: the receive-side counterpart of the checksum generator. It accepts a byte stream in which each frame ends with a 4-byte Adler-32 trailer. It accumulates the checksum over the payload bytes, compares it with the trailer, and reports one pass/fail result per frame on a valid/ready output channel. It sits after the byte-stream deframer and ahead of the frame-status consumer.

## Interface
Parameters:
- TRAILER_MSB_FIRST, default 1: trailer byte order. 1 means big-endian, as in zlib. 0 means little-endian.
- STAT_W, default 16: width of the statistics counters. Only used when ADLER32_CHK_STATS_EN is defined.

Ports:
- clk  in  1  Single clock. All logic is on the rising edge.
- rst_n  in  1  Reset. Asynchronous assert, active-low.
- in_data  in  8  Stream byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  Marks the final trailer byte of the frame.
- in_ready  out  1  The block can accept a byte.
- res_valid  out  1  A frame result is available.
- res_ready  in  1  The consumer accepts the result.
- res_ok  out  1  The computed checksum equals the trailer and the frame is not a runt.
- res_runt  out  1  The frame had fewer than 4 bytes.
- res_calc  out  32  Computed checksum, {B[15:0], A[15:0]}.
- res_recv  out  32  Received trailer value.
- stat_good, stat_bad  out  STAT_W  Frame counters. Present only with ADLER32_CHK_STATS_EN.

## Operation
- Accumulators A and B are 16 bits each. Start values: A=1, B=0. Modulus M=65521.
- A byte is accepted when in_valid & in_ready.
- Delay line: accepted bytes shift through a 4-byte buffer with an occupancy count of 0 to 4.
  - A byte is added to the checksum only when it is pushed out of a full buffer. The last 4 bytes of a frame are therefore never summed.
- Per summed byte d:
  - a1 = A + d (17 bits); A' = a1 ≥ M ? a1 − M : a1.
  - b1 = B + A' (17 bits); B' = b1 ≥ M ? b1 − M : b1.
  - One byte is summed per cycle, with no stall.
- On the in_last beat:
  - The buffer plus the incoming byte form the trailer.
  - If occupancy before this beat is below 3, the frame is a runt: res_runt=1, res_ok=0, res_recv=0.
  - The byte shifted out on the in_last beat itself is summed before comparison.
- States:
  - RUN: in_ready=1. An in_last handshake loads the result registers, goes to REPORT, clears the buffer, and resets A=1, B=0.
  - REPORT: in_ready=0 and res_valid=1. res_valid & res_ready returns to RUN.
- in_last is the only frame delimiter. A new frame may begin in the cycle after the result is accepted.

## Timing
- Reset values:
  - State RUN, in_ready=1.
  - res_valid=0, res_ok=0, res_runt=0, res_calc=0, res_recv=0.
  - A=1, B=0, buffer occupancy 0, stat counters 0.
- Latency: res_valid rises in the cycle after the in_last handshake.
- Result fields are stable while res_valid=1 and res_ready=0.
- Throughput: 1 byte per cycle within a frame. Each frame costs at least 1 bubble cycle (REPORT).
- in_valid while in REPORT is ignored. The byte is not consumed.
- in_last with in_valid=0 has no effect.
- Reset asserted mid-frame or mid-REPORT discards all state immediately. The pending result is lost.

## Configuration
- ADLER32_CHK_STATS_EN defined:
  - stat_good increments on each res_valid & res_ready with res_ok=1.
  - stat_bad increments on each such handshake with res_ok=0, runts included.
  - Both counters saturate at all-ones.
- Not defined: the stat ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package adler32_pkg holds:
  - ADLER_MOD = 16'd65521 and ADLER_INIT = 32'h0000_0001.
  - The typedef adler32_t, a struct {b, a} of 16 bits each.
  - The result-status struct {ok, runt, calc, recv}.
- One sub-module, adler32_step: combinational (A, B, d) → (A', B') with the two conditional subtractions. It is reusable by the generator.
- FSM, delay buffer and handshake stay in adler32_check.

## Test plan
- "Wikipedia" (9 bytes) followed by trailer 11 E6 03 98, last on 0x98 → res_calc=0x11E60398, res_recv=0x11E60398, res_ok=1.
- Same payload with trailer 11 E6 03 99 → res_ok=0, res_calc=0x11E60398, res_recv=0x11E60399.
- Empty payload, trailer 00 00 00 01 → res_ok=1. Then a 2-byte frame AB CD with last → res_runt=1, res_ok=0.
- 5552 bytes of 0xFF plus a correct trailer, compared against a software model → res_ok=1, exercising the A and B wrap at 65521.
- Hold res_ready=0 for 10 cycles after a result while driving in_valid=1 → in_ready=0, no byte consumed, result stable. Release → RUN, and the next frame checks correctly.
- Assert rst_n=0 mid-frame after 5 bytes, then send a full valid frame → single result with res_ok=1. With STATS_EN, stat_good=1 and stat_bad=0.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared Adler-32 types and constants for the checker and the generator.
package adler32_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned HALF_W     = 16;
    localparam int unsigned SUM_W      = 32;
    localparam int unsigned TRL_BYTES  = 4;
    localparam int unsigned OCC_W      = 3;

    localparam logic [15:0] ADLER_MOD  = 16'd65521;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    // Running checksum, packed in the same order as the on-wire value.
    typedef struct packed {
        logic [15:0] b;
        logic [15:0] a;
    } adler32_t;

    // Per-frame verdict handed to the status consumer.
    typedef struct packed {
        logic        ok;
        logic        runt;
        adler32_t    calc;
        logic [31:0] recv;
    } adler32_res_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REPORT = 1'b1
    } chk_state_e;

endpackage

// File: rtl/adler32_step.sv
// One-byte Adler-32 update: (A, B, d) -> (A', B') with modular reduction.
module adler32_step
    import adler32_pkg::*;
(
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [7:0]  d_in,
    output logic [15:0] a_next_c,
    output logic [15:0] b_next_c
);

    logic [16:0] a1;
    logic [16:0] b1;

    // Inputs are always below the modulus, so one conditional subtract suffices.
    always_comb begin
        a1       = 17'(a_in) + 17'(d_in);
        a_next_c = (a1 >= 17'(ADLER_MOD)) ? 16'(a1 - 17'(ADLER_MOD)) : a1[15:0];
        b1       = 17'(b_in) + 17'(a_next_c);
        b_next_c = (b1 >= 17'(ADLER_MOD)) ? 16'(b1 - 17'(ADLER_MOD)) : b1[15:0];
    end

endmodule

// File: rtl/adler32_check.sv
// Streaming Adler-32 frame checker. The last four bytes of each frame are the
// trailer; a 4-byte delay line keeps them out of the running sum.
// Optional frame counters: define ADLER32_CHK_STATS_EN.
module adler32_check
    import adler32_pkg::*;
#(
    parameter int unsigned TRAILER_MSB_FIRST = 1,
    parameter int unsigned STAT_W            = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_ok,
    output logic        res_runt,
    output logic [31:0] res_calc,
    output logic [31:0] res_recv
`ifdef ADLER32_CHK_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_good,
    output logic [STAT_W-1:0] stat_bad
`endif
);

    chk_state_e              state_q;
    chk_state_e              state_d;
    logic [TRL_BYTES-1:0][BYTE_W-1:0] dly_q;
    logic [OCC_W-1:0]        occ_q;
    adler32_t                acc_q;
    adler32_res_t            res_q;
    adler32_res_t            res_d;

    logic                    in_fire;
    logic                    sum_en;
    logic [HALF_W-1:0]       step_a_c;
    logic [HALF_W-1:0]       step_b_c;
    adler32_t                sum_cur;
    logic [SUM_W-1:0]        trl_arr;
    logic [SUM_W-1:0]        recv_val;
    logic                    runt;

    assign in_fire = in_valid & in_ready;

    adler32_step u_step (
        .a_in     (acc_q.a),
        .b_in     (acc_q.b),
        .d_in     (dly_q[0]),
        .a_next_c (step_a_c),
        .b_next_c (step_b_c)
    );

    // Next-state logic for the RUN/REPORT handshake FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (in_fire && in_last) state_d = ST_REPORT;
            ST_REPORT: if (res_ready)          state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Checksum with the outgoing byte folded in, trailer assembly and verdict.
    always_comb begin
        sum_en  = (occ_q == OCC_W'(TRL_BYTES));
        sum_cur = acc_q;
        if (sum_en) begin
            sum_cur.a = step_a_c;
            sum_cur.b = step_b_c;
        end
        // trl_arr holds the trailer in arrival order, first byte in the MSBs.
        if (sum_en) trl_arr = {dly_q[1], dly_q[2], dly_q[3], in_data};
        else        trl_arr = {dly_q[0], dly_q[1], dly_q[2], in_data};
        if (TRAILER_MSB_FIRST != 0) recv_val = trl_arr;
        else recv_val = {trl_arr[7:0], trl_arr[15:8], trl_arr[23:16], trl_arr[31:24]};
        runt       = (occ_q < OCC_W'(TRL_BYTES - 1));
        res_d.runt = runt;
        res_d.calc = sum_cur;
        res_d.recv = runt ? 32'd0 : recv_val;
        res_d.ok   = !runt && (SUM_W'(sum_cur) == recv_val);
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ST_RUN);
            res_valid <= (state_d == ST_REPORT);
        end
    end

    // Delay line, accumulators and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
            occ_q <= '0;
            acc_q <= adler32_t'(ADLER_INIT);
            res_q <= '0;
        end else if (in_fire) begin
            if (in_last) begin
                res_q <= res_d;
                occ_q <= '0;
                acc_q <= adler32_t'(ADLER_INIT);
            end else if (sum_en) begin
                dly_q[0] <= dly_q[1];
                dly_q[1] <= dly_q[2];
                dly_q[2] <= dly_q[3];
                dly_q[3] <= in_data;
                acc_q    <= sum_cur;
            end else begin
                dly_q[occ_q[1:0]] <= in_data;
                occ_q             <= occ_q + OCC_W'(1);
            end
        end
    end

    assign res_ok   = res_q.ok;
    assign res_runt = res_q.runt;
    assign res_calc = SUM_W'(res_q.calc);
    assign res_recv = res_q.recv;

`ifdef ADLER32_CHK_STATS_EN
    logic res_fire;
    assign res_fire = res_valid & res_ready;

    // Saturating good/bad frame counters, stepped on each accepted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good <= '0;
            stat_bad  <= '0;
        end else if (res_fire) begin
            if (res_q.ok) begin
                if (stat_good != {STAT_W{1'b1}}) stat_good <= stat_good + STAT_W'(1);
            end else begin
                if (stat_bad != {STAT_W{1'b1}}) stat_bad <= stat_bad + STAT_W'(1);
            end
        end
    end
`else
    localparam int unsigned unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_adler32_check.sv
// Directed testbench for adler32_check (default big-endian trailer).
module tb_adler32_check;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic        res_runt;
    logic [31:0] res_calc;
    logic [31:0] res_recv;
`ifdef ADLER32_CHK_STATS_EN
    logic [15:0] stat_good;
    logic [15:0] stat_bad;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] frame_q[$];

    adler32_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_runt  (res_runt),
        .res_calc  (res_calc),
        .res_recv  (res_recv)
`ifdef ADLER32_CHK_STATS_EN
        ,
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_wiki(input logic [31:0] trl);
        frame_q = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
        frame_q.push_back(trl[31:24]);
        frame_q.push_back(trl[23:16]);
        frame_q.push_back(trl[15:8]);
        frame_q.push_back(trl[7:0]);
    endtask

    // Streams frame_q, one byte per accepted beat; optionally marks the final byte last.
    task automatic send_frame(input bit with_last);
        for (int i = 0; i < frame_q.size(); i++) begin
            int budget;
            budget = 0;
            @(negedge clk);
            in_data  = frame_q[i];
            in_last  = with_last && (i == frame_q.size() - 1);
            in_valid = 1'b1;
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                check("ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (with_last) check("latency", 32'(res_valid), 32'd1);
    endtask

    task automatic get_result(input string tag, input logic ok, input logic runt,
                              input logic [31:0] calc, input logic [31:0] recv);
        int budget;
        budget = 0;
        while (!res_valid && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_ok"},    32'(res_ok),    32'(ok));
        check({tag, "_runt"},  32'(res_runt),  32'(runt));
        check({tag, "_calc"},  res_calc,       calc);
        check({tag, "_recv"},  res_recv,       recv);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_done"},  32'(res_valid), 32'd0);
        check({tag, "_rdy"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_ok",    32'(res_ok),    32'd0);
        check("rst_res_runt",  32'(res_runt),  32'd0);
        check("rst_res_calc",  res_calc,       32'd0);
        check("rst_res_recv",  res_recv,       32'd0);
        rst_n = 1'b1;

        // in_last without in_valid must not produce a result
        @(negedge clk);
        in_last = 1'b1;
        repeat (3) @(negedge clk);
        check("last_no_valid", 32'(res_valid), 32'd0);
        in_last = 1'b0;

        set_wiki(32'h11E6_0398);
        send_frame(1'b1);
        get_result("wiki_good", 1'b1, 1'b0, 32'h11E6_0398, 32'h11E6_0398);

        set_wiki(32'h11E6_0399);
        send_frame(1'b1);
        get_result("wiki_bad", 1'b0, 1'b0, 32'h11E6_0398, 32'h11E6_0399);

        frame_q = '{8'h00, 8'h00, 8'h00, 8'h01};
        send_frame(1'b1);
        get_result("empty", 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001);

        frame_q = '{8'hAB, 8'hCD};
        send_frame(1'b1);
        get_result("runt", 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000);

        // 5552 x 0xFF: A = 1+5552*255 mod 65521 = 0x9B8C, B = 0xF18F
        frame_q.delete();
        repeat (5552) frame_q.push_back(8'hFF);
        frame_q.push_back(8'hF1);
        frame_q.push_back(8'h8F);
        frame_q.push_back(8'h9B);
        frame_q.push_back(8'h8C);
        send_frame(1'b1);
        get_result("wrap", 1'b1, 1'b0, 32'hF18F_9B8C, 32'hF18F_9B8C);

        // Backpressure on the result: input must be refused and the result held
        set_wiki(32'h11E6_0398);
        send_frame(1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_calc",  res_calc,       32'h11E6_0398);
        end
        in_valid = 1'b0;
        get_result("hold", 1'b1, 1'b0, 32'h11E6_0398, 32'h11E6_0398);
        set_wiki(32'h11E6_0398);
        send_frame(1'b1);
        get_result("after_hold", 1'b1, 1'b0, 32'h11E6_0398, 32'h11E6_0398);

        // Reset in the middle of a frame discards the partial frame
        frame_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        send_frame(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_res_calc",  res_calc,       32'd0);
        rst_n = 1'b1;
        set_wiki(32'h11E6_0398);
        send_frame(1'b1);
        get_result("post_rst", 1'b1, 1'b0, 32'h11E6_0398, 32'h11E6_0398);
`ifdef ADLER32_CHK_STATS_EN
        check("stat_good", 32'(stat_good), 32'd1);
        check("stat_bad",  32'(stat_bad),  32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
